// File: rtl/seq_multiplier_64.sv
// Radix-2 shift-add multiplier for the RV64 M-extension multiply family.
// It computes one multiplier bit per cycle on sign-stripped operands, then
// applies the product sign and selects the requested 64-bit half.
//
// state | meaning
// IDLE  | waiting for start; operands, op and sign are latched on start
// CALC  | 64 shift-add steps, multiplier consumed LSB-first
// SIGN  | apply the product sign, load result, pulse done
module seq_multiplier_64 #(
  parameter int WIDTH = 64
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [1:0]       mul_op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] result
);

  localparam int CW = $clog2(WIDTH);
  localparam logic [1:0] OP_MUL    = 2'b00;
  localparam logic [1:0] OP_MULH   = 2'b01;
  localparam logic [1:0] OP_MULHSU = 2'b10;
  localparam logic [WIDTH-1:0]   ONE_W  = WIDTH'(1);
  localparam logic [2*WIDTH-1:0] ONE_2W = (2*WIDTH)'(1);
  localparam logic [CW-1:0]      CNT_LAST = CW'(WIDTH - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    SIGN = 2'd2
  } state_t;

  state_t             state_q, state_d;
  logic [1:0]         op_q, op_d;
  logic [WIDTH-1:0]   mcand_q, mcand_d;
  logic [WIDTH-1:0]   mplier_q, mplier_d;
  logic [2*WIDTH-1:0] acc_q, acc_d;
  logic [CW-1:0]      cnt_q, cnt_d;
  logic               neg_q, neg_d;
  logic [WIDTH-1:0]   result_q, result_d;
  logic               busy_q, busy_d;
  logic               done_q, done_d;

  logic               a_signed, b_signed;
  logic               a_neg, b_neg;
  logic [WIDTH-1:0]   a_abs, b_abs;
  logic [WIDTH:0]     sum;
  logic [2*WIDTH-1:0] prod;

  // Operand conditioning, the 65-bit partial sum and the signed product.
  // The magnitude of the most negative value is itself, read as unsigned.
  always_comb begin
    a_signed = (mul_op == OP_MULH) || (mul_op == OP_MULHSU);
    b_signed = (mul_op == OP_MULH);
    a_neg    = a_signed && a[WIDTH-1];
    b_neg    = b_signed && b[WIDTH-1];
    a_abs    = a_neg ? (~a + ONE_W) : a;
    b_abs    = b_neg ? (~b + ONE_W) : b;
    sum      = {1'b0, acc_q[2*WIDTH-1:WIDTH]} +
               (mplier_q[0] ? {1'b0, mcand_q} : {(WIDTH+1){1'b0}});
    prod     = neg_q ? (~acc_q + ONE_2W) : acc_q;
  end

  // Next-state and datapath control.
  always_comb begin
    state_d  = state_q;
    op_d     = op_q;
    mcand_d  = mcand_q;
    mplier_d = mplier_q;
    acc_d    = acc_q;
    cnt_d    = cnt_q;
    neg_d    = neg_q;
    result_d = result_q;
    busy_d   = busy_q;
    done_d   = 1'b0;
    case (state_q)
      IDLE: begin
        if (start) begin
          op_d     = mul_op;
          mcand_d  = a_abs;
          mplier_d = b_abs;
          neg_d    = a_neg ^ b_neg;
          acc_d    = '0;
          cnt_d    = '0;
          busy_d   = 1'b1;
          state_d  = CALC;
        end
      end
      CALC: begin
        // Carry out of the add lands in bit 127 after the shift.
        acc_d    = {sum, acc_q[WIDTH-1:1]};
        mplier_d = mplier_q >> 1;
        cnt_d    = cnt_q + CW'(1);
        if (cnt_q == CNT_LAST) begin
          state_d = SIGN;
        end
      end
      SIGN: begin
        result_d = (op_q == OP_MUL) ? prod[WIDTH-1:0] : prod[2*WIDTH-1:WIDTH];
        done_d   = 1'b1;
        busy_d   = 1'b0;
        state_d  = IDLE;
      end
      default: begin
        busy_d  = 1'b0;
        state_d = IDLE;
      end
    endcase
  end

  // State and datapath registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= IDLE;
      op_q     <= '0;
      mcand_q  <= '0;
      mplier_q <= '0;
      acc_q    <= '0;
      cnt_q    <= '0;
      neg_q    <= 1'b0;
      result_q <= '0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      op_q     <= op_d;
      mcand_q  <= mcand_d;
      mplier_q <= mplier_d;
      acc_q    <= acc_d;
      cnt_q    <= cnt_d;
      neg_q    <= neg_d;
      result_q <= result_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
    end
  end

  assign busy   = busy_q;
  assign done   = done_q;
  assign result = result_q;

endmodule

// File: tb/tb_seq_multiplier_64.sv
// Directed bench for seq_multiplier_64: latency, handshake, all four ops,
// signed corners, start-while-busy, reset mid-operation and back-to-back.
module tb_seq_multiplier_64;

  localparam logic [1:0] OP_MUL    = 2'b00;
  localparam logic [1:0] OP_MULH   = 2'b01;
  localparam logic [1:0] OP_MULHSU = 2'b10;
  localparam logic [1:0] OP_MULHU  = 2'b11;
  localparam int LIMIT = 200;

  logic        clk = 1'b0;
  logic        reset;
  logic        start;
  logic [1:0]  mul_op;
  logic [63:0] a;
  logic [63:0] b;
  logic        busy;
  logic        done;
  logic [63:0] result;

  int errors = 0;
  int checks = 0;

  seq_multiplier_64 #(.WIDTH(64)) dut (
    .clk    (clk),
    .reset  (reset),
    .start  (start),
    .mul_op (mul_op),
    .a      (a),
    .b      (b),
    .busy   (busy),
    .done   (done),
    .result (result)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Present a request for one edge (edge N); returns sampled just after N.
  task automatic launch(input logic [1:0] op, input logic [63:0] av, input logic [63:0] bv);
    mul_op = op;
    a      = av;
    b      = bv;
    start  = 1'b1;
    tick();
    start  = 1'b0;
  endtask

  // Count edges until done is seen (bounded); also counts busy-high samples before done.
  task automatic wait_done(output int n, output int busy_n);
    n = 0;
    busy_n = 0;
    do begin
      tick();
      n++;
      if (!done && busy) busy_n++;
    end while (!done && n < LIMIT);
  endtask

  // Run one op and check latency, busy span and result.
  task automatic run_op(input string tag, input logic [1:0] op, input logic [63:0] av,
                        input logic [63:0] bv, input logic [63:0] exp);
    int n, bn;
    launch(op, av, bv);
    check({tag, "_busy_start"}, 64'(busy), 64'd1);
    wait_done(n, bn);
    check({tag, "_latency"}, 64'(n), 64'd65);
    check({tag, "_result"}, result, exp);
  endtask

  initial begin
    int n, bn, extra;
    reset  = 1'b1;
    start  = 1'b0;
    mul_op = OP_MUL;
    a      = '0;
    b      = '0;
    tick();
    tick();
    check("rst_busy", 64'(busy), 64'd0);
    check("rst_done", 64'(done), 64'd0);
    check("rst_result", result, 64'd0);
    reset = 1'b0;
    tick();

    // MUL 3x5 with latency and busy span
    launch(OP_MUL, 64'd3, 64'd5);
    check("mul35_busy_start", 64'(busy), 64'd1);
    wait_done(n, bn);
    check("mul35_latency", 64'(n), 64'd65);
    check("mul35_busy_cycles", 64'(bn + 1), 64'd65);
    check("mul35_busy_at_done", 64'(busy), 64'd0);
    check("mul35_result", result, 64'h0000_0000_0000_000F);
    tick();
    check("mul35_done_one_cycle", 64'(done), 64'd0);
    check("mul35_result_hold", result, 64'h0000_0000_0000_000F);

    run_op("mulh_m1m1",  OP_MULH,  64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFF, 64'h0);
    run_op("mul_m1m1",   OP_MUL,   64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFF, 64'h1);
    run_op("mulhu_m1m1", OP_MULHU, 64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFF,
           64'hFFFF_FFFF_FFFF_FFFE);
    run_op("mulhsu_m1", OP_MULHSU, 64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFF,
           64'hFFFF_FFFF_FFFF_FFFF);
    run_op("mulh_min", OP_MULH, 64'h8000_0000_0000_0000, 64'h8000_0000_0000_0000,
           64'h4000_0000_0000_0000);
    // -3 * 5 = -15: high half all ones, low half 0xF..F1
    run_op("mulh_neg", OP_MULH, 64'hFFFF_FFFF_FFFF_FFFD, 64'd5, 64'hFFFF_FFFF_FFFF_FFFF);
    run_op("mul_neg",  OP_MUL,  64'hFFFF_FFFF_FFFF_FFFD, 64'd5, 64'hFFFF_FFFF_FFFF_FFF1);
    // 2^32 * 2^32 = 2^64: high half 1, low half 0
    run_op("mulhu_2_64", OP_MULHU, 64'h1_0000_0000, 64'h1_0000_0000, 64'h1);

    // Start while busy and operand changes mid-operation
    launch(OP_MUL, 64'd7, 64'd9);
    a = 64'hDEAD_BEEF_0000_1234;
    b = 64'h1234_5678_9ABC_DEF0;
    mul_op = OP_MULHU;
    for (int i = 0; i < 9; i++) tick();
    a = 64'd2;
    b = 64'd2;
    start = 1'b1;
    tick();
    start = 1'b0;
    a = 64'hFFFF_0000_FFFF_0000;
    wait_done(n, bn);
    check("busy_ign_latency", 64'(n + 10), 64'd65);
    check("busy_ign_result", result, 64'd63);
    extra = 0;
    for (int i = 0; i < 80; i++) begin
      tick();
      if (done) extra++;
    end
    check("busy_ign_single_done", 64'(extra), 64'd0);
    check("busy_ign_idle", 64'(busy), 64'd0);

    // Reset mid-operation
    launch(OP_MUL, 64'd1000, 64'd1000);
    for (int i = 0; i < 29; i++) tick();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    check("rst_mid_busy", 64'(busy), 64'd0);
    check("rst_mid_done", 64'(done), 64'd0);
    check("rst_mid_result", result, 64'd0);
    extra = 0;
    for (int i = 0; i < 80; i++) begin
      tick();
      if (done || busy) extra++;
    end
    check("rst_mid_no_done", 64'(extra), 64'd0);
    run_op("after_rst_4x4", OP_MUL, 64'd4, 64'd4, 64'd16);

    // Reset and start together: reset wins
    mul_op = OP_MUL;
    a = 64'd5;
    b = 64'd5;
    start = 1'b1;
    reset = 1'b1;
    tick();
    start = 1'b0;
    reset = 1'b0;
    check("rst_start_busy", 64'(busy), 64'd0);
    tick();
    check("rst_start_still_idle", 64'(busy), 64'd0);

    // Back-to-back: new start presented during the done cycle
    launch(OP_MUL, 64'd6, 64'd7);
    wait_done(n, bn);
    check("b2b_first_result", result, 64'd42);
    launch(OP_MULHU, 64'h8000_0000_0000_0000, 64'd4);
    check("b2b_accepted", 64'(busy), 64'd1);
    check("b2b_done_low", 64'(done), 64'd0);
    wait_done(n, bn);
    check("b2b_latency", 64'(n), 64'd65);
    check("b2b_result", result, 64'h0000_0000_0000_0002);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
